// File: rtl/seg_value_display_if.sv
// Handshake and display bus for seg_value_display.
// The master side supplies samples; the slave side reports status
// and drives the six active-low 7-segment digit codes.
interface seg_value_display_if;
  logic [15:0] data_in;
  logic        data_valid;
  logic        ready;
  logic        done;
  logic [7:0]  seg5;
  logic [7:0]  seg4;
  logic [7:0]  seg3;
  logic [7:0]  seg2;
  logic [7:0]  seg1;
  logic [7:0]  seg0;

  modport master (
    output data_in, data_valid,
    input  ready, done, seg5, seg4, seg3, seg2, seg1, seg0
  );

  modport slave (
    input  data_in, data_valid,
    output ready, done, seg5, seg4, seg3, seg2, seg1, seg0
  );
endinterface

// File: rtl/seg_value_display.sv
// Signed 16-bit sample to six active-low 7-segment codes.
// Magnitude goes through a 16-step shift-add-3 binary-to-BCD loop, then a
// single encode cycle builds the sign digit, five magnitude digits, optional
// leading-zero blanking and a fixed decimal point.
// Segment bit order is {dp,g,f,e,d,c,b,a}.
module seg_value_display #(
  parameter int BLANK_LZ = 1,
  parameter int DP_POS   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  seg_value_display_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_ENCODE = 2'd2;

  // With no decimal point the units digit is the lowest one that may stay lit.
  localparam int BLANK_LIM = (DP_POS > 4) ? 0 : DP_POS;

  logic [1:0]       state;
  logic             sign;
  logic [15:0]      mag;
  logic [19:0]      bcd;
  logic [19:0]      bcd_adj;
  logic [4:0]       bit_cnt;
  logic             done_q;
  logic [5:0][7:0]  seg_q;
  logic [5:0][7:0]  seg_next;
  logic             zero_run;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hF8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      default: seg_of = 8'hFF;
    endcase
  endfunction

  // Add-3 correction on every BCD nibble that would overflow on the next shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Build the display codes: walk from the top digit down tracking a run of zeros.
  always_comb begin
    seg_next = '1;
    zero_run = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      zero_run    = zero_run & (bcd[k*4 +: 4] == 4'd0);
      seg_next[k] = seg_of(bcd[k*4 +: 4]);
      if (BLANK_LZ != 0 && k > BLANK_LIM && zero_run) begin
        seg_next[k] = 8'hFF;
      end
      if (k == DP_POS) begin
        seg_next[k][7] = 1'b0;
      end
    end
    seg_next[5] = (sign && (bcd != 20'd0)) ? 8'hBF : 8'hFF;
  end

  // Conversion sequencer: accept in IDLE, shift 16 times, encode once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      sign    <= 1'b0;
      mag     <= 16'd0;
      bcd     <= 20'd0;
      bit_cnt <= 5'd0;
      done_q  <= 1'b0;
      seg_q   <= '1;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.data_valid) begin
            sign    <= bus.data_in[15];
            mag     <= bus.data_in[15] ? (~bus.data_in + 16'd1) : bus.data_in;
            bcd     <= 20'd0;
            bit_cnt <= 5'd16;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd     <= {bcd_adj[18:0], mag[15]};
          mag     <= {mag[14:0], 1'b0};
          bit_cnt <= bit_cnt - 5'd1;
          if (bit_cnt == 5'd1) begin
            state <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          seg_q  <= seg_next;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.done  = done_q;
  assign bus.seg5  = seg_q[5];
  assign bus.seg4  = seg_q[4];
  assign bus.seg3  = seg_q[3];
  assign bus.seg2  = seg_q[2];
  assign bus.seg1  = seg_q[1];
  assign bus.seg0  = seg_q[0];

endmodule

// File: tb/tb_seg_value_display.sv
// Directed bench for seg_value_display.
// Two instances share stimulus: dut_a uses blanking with DP on digit 3,
// dut_b shows all digits with no decimal point.
module tb_seg_value_display;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  seg_value_display_if bus_a ();
  seg_value_display_if bus_b ();

  seg_value_display #(.BLANK_LZ(1), .DP_POS(3)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a.slave)
  );

  seg_value_display #(.BLANK_LZ(0), .DP_POS(7)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b.slave)
  );

  logic [47:0] segs_a;
  logic [47:0] segs_b;
  assign segs_a = {bus_a.seg5, bus_a.seg4, bus_a.seg3, bus_a.seg2, bus_a.seg1, bus_a.seg0};
  assign segs_b = {bus_b.seg5, bus_b.seg4, bus_b.seg3, bus_b.seg2, bus_b.seg1, bus_b.seg0};

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive a value into both instances from a negedge and wait for done.
  // Returns the number of negedges between acceptance and done (40 = timeout).
  task automatic run_conv(input logic [15:0] v, output int cycles, output bit early_ready);
    bus_a.data_in    = v;
    bus_b.data_in    = v;
    bus_a.data_valid = 1'b1;
    bus_b.data_valid = 1'b1;
    @(negedge clk);
    bus_a.data_valid = 1'b0;
    bus_b.data_valid = 1'b0;
    cycles      = 0;
    early_ready = 1'b0;
    while (!bus_a.done && cycles < 40) begin
      if (bus_a.ready) early_ready = 1'b1;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset_n          = 1'b0;
    bus_a.data_valid = 1'b0;
    bus_b.data_valid = 1'b0;
    bus_a.data_in    = 16'd0;
    bus_b.data_in    = 16'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_a.ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b expected 1", bus_a.ready);
    end
    n_checks++;
    if (bus_a.done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_done: got %b expected 0", bus_a.done);
    end
    n_checks++;
    if (segs_a !== 48'hFFFF_FFFF_FFFF) begin
      n_fail++;
      $display("[TB] FAIL reset_segs_a: got %h expected ffffffffffff", segs_a);
    end
    n_checks++;
    if (segs_b !== 48'hFFFF_FFFF_FFFF) begin
      n_fail++;
      $display("[TB] FAIL reset_segs_b: got %h expected ffffffffffff", segs_b);
    end
  endtask

  task automatic test_basic();
    int cycles;
    bit early;
    run_conv(16'd1234, cycles, early);
    n_checks++;
    if (cycles !== 17) begin
      n_fail++;
      $display("[TB] FAIL basic_latency: got %0d expected 17", cycles);
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_busy_ready: got ready=1 during conversion expected 0");
    end
    n_checks++;
    if (bus_a.ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_ready_at_done: got %b expected 1", bus_a.ready);
    end
    n_checks++;
    if (segs_a !== 48'hFFFF_79A4_B099) begin
      n_fail++;
      $display("[TB] FAIL basic_segs_a: got %h expected ffff79a4b099", segs_a);
    end
    n_checks++;
    if (segs_b !== 48'hFFC0_F9A4_B099) begin
      n_fail++;
      $display("[TB] FAIL basic_segs_b: got %h expected ffc0f9a4b099", segs_b);
    end
    @(negedge clk);
    n_checks++;
    if (bus_a.done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_done_width: got %b expected 0", bus_a.done);
    end
  endtask

  task automatic test_values();
    logic [15:0] vals [3];
    logic [47:0] exp_a [3];
    logic [47:0] exp_b [3];
    int cycles;
    bit early;
    vals[0] = 16'h8000; exp_a[0] = 48'hBFB0_24F8_8280; exp_b[0] = 48'hBFB0_A4F8_8280;
    vals[1] = 16'hFFFB; exp_a[1] = 48'hBFFF_40C0_C092; exp_b[1] = 48'hBFC0_C0C0_C092;
    vals[2] = 16'h0000; exp_a[2] = 48'hFFFF_40C0_C0C0; exp_b[2] = 48'hFFC0_C0C0_C0C0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      run_conv(vals[i], cycles, early);
      n_checks++;
      if (cycles !== 17) begin
        n_fail++;
        $display("[TB] FAIL value%0d_latency: got %0d expected 17", i, cycles);
      end
      n_checks++;
      if (segs_a !== exp_a[i]) begin
        n_fail++;
        $display("[TB] FAIL value%0d_segs_a: got %h expected %h", i, segs_a, exp_a[i]);
      end
      n_checks++;
      if (segs_b !== exp_b[i]) begin
        n_fail++;
        $display("[TB] FAIL value%0d_segs_b: got %h expected %h", i, segs_b, exp_b[i]);
      end
    end
  endtask

  task automatic test_drop();
    int dones;
    @(negedge clk);
    bus_a.data_in    = 16'd1234;
    bus_b.data_in    = 16'd1234;
    bus_a.data_valid = 1'b1;
    bus_b.data_valid = 1'b1;
    @(negedge clk);
    bus_a.data_valid = 1'b0;
    bus_b.data_valid = 1'b0;
    dones = 0;
    for (int c = 0; c < 45; c++) begin
      if (c == 5) begin
        bus_a.data_in    = 16'd999;
        bus_b.data_in    = 16'd999;
        bus_a.data_valid = 1'b1;
        bus_b.data_valid = 1'b1;
      end else begin
        bus_a.data_valid = 1'b0;
        bus_b.data_valid = 1'b0;
      end
      @(negedge clk);
      if (bus_a.done) dones++;
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("[TB] FAIL drop_done_count: got %0d expected 1", dones);
    end
    n_checks++;
    if (segs_a !== 48'hFFFF_79A4_B099) begin
      n_fail++;
      $display("[TB] FAIL drop_segs_a: got %h expected ffff79a4b099", segs_a);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    int cycles;
    bit early;
    @(negedge clk);
    bus_a.data_in    = 16'd1234;
    bus_b.data_in    = 16'd1234;
    bus_a.data_valid = 1'b1;
    bus_b.data_valid = 1'b1;
    @(negedge clk);
    bus_a.data_valid = 1'b0;
    bus_b.data_valid = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_a.done) dones++;
    end
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus_a.done) dones++;
    end
    reset_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (bus_a.done) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("[TB] FAIL abort_done_count: got %0d expected 0", dones);
    end
    n_checks++;
    if (segs_a !== 48'hFFFF_FFFF_FFFF) begin
      n_fail++;
      $display("[TB] FAIL abort_segs_a: got %h expected ffffffffffff", segs_a);
    end
    n_checks++;
    if (bus_a.ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_ready: got %b expected 1", bus_a.ready);
    end
    run_conv(16'hFFFB, cycles, early);
    n_checks++;
    if (cycles !== 17) begin
      n_fail++;
      $display("[TB] FAIL abort_next_latency: got %0d expected 17", cycles);
    end
    n_checks++;
    if (segs_a !== 48'hBFFF_40C0_C092) begin
      n_fail++;
      $display("[TB] FAIL abort_next_segs_a: got %h expected bfff40c0c092", segs_a);
    end
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    bit early;
    @(negedge clk);
    run_conv(16'd1234, c1, early);
    run_conv(16'hFFFB, c2, early);
    n_checks++;
    if (c1 !== 17) begin
      n_fail++;
      $display("[TB] FAIL b2b_first_latency: got %0d expected 17", c1);
    end
    n_checks++;
    if (c2 !== 17) begin
      n_fail++;
      $display("[TB] FAIL b2b_second_latency: got %0d expected 17", c2);
    end
    n_checks++;
    if (segs_b !== 48'hBFC0_C0C0_C092) begin
      n_fail++;
      $display("[TB] FAIL b2b_segs_b: got %h expected bfc0c0c0c092", segs_b);
    end
  endtask

  // Test sequence.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_values();
    test_drop();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_value_display.md
Name: seg_value_display

Overview:
- Converts a signed 16-bit sample into six active-low 7-segment codes, using an iterative shift-add-3 binary-to-BCD conversion.
- Typical source: an accelerometer axis in mg, read over I2C by the CPU or a hardware reader.
- Sits directly upstream of the six 8-bit seg outputs (seg5..seg0), replacing per-digit software writes.
- Digit 5 shows the sign; digits 4..0 show the magnitude, with optional leading-zero blanking and a fixed decimal point.

Parameters:
- BLANK_LZ, 1, 1 = blank leading zeros above DP_POS; 0 = show all five magnitude digits.
- DP_POS, 3, magnitude digit index (0..4) whose decimal point is lit; 7 = no decimal point.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- data_in  input  16  signed two's-complement value.
- data_valid  input  1  data_in is valid; accepted only on a clock edge where ready=1.
- ready  output  1  block is idle and can accept a value.
- done  output  1  one-cycle pulse when seg5..seg0 have just updated.
- seg5  output  8  sign digit.
- seg4  output  8  magnitude digit 4 (ten-thousands).
- seg3  output  8  magnitude digit 3.
- seg2  output  8  magnitude digit 2.
- seg1  output  8  magnitude digit 1.
- seg0  output  8  magnitude digit 0 (units).

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state = IDLE, ready=1, done=0, seg5..seg0 = 8'hFF (all blank).
  - Asserting reset mid-conversion aborts it; no done pulse is produced.
- Segment format: bit order {dp,g,f,e,d,c,b,a}, active-low.
  - Digits 0-9: C0,F9,A4,B0,99,92,82,F8,80,90.
  - Minus sign = BF. Blank = FF.
  - A lit decimal point clears bit 7.
- States: IDLE, SHIFT, ENCODE.
- IDLE:
  - ready=1.
  - On an edge with data_valid=1: latch sign = data_in[15] and mag = |data_in| as 16-bit unsigned (-32768 gives 0x8000 = 32768); clear the 20-bit BCD accumulator; load the bit counter with 16; go to SHIFT.
- SHIFT:
  - ready=0.
  - Each cycle: every BCD nibble >= 5 gets +3, then {bcd,mag} shifts left by 1.
  - After 16 shifts, go to ENCODE.
- ENCODE (one cycle):
  - Register all six seg outputs from the BCD and sign, pulse done=1, return to IDLE.
- Latency:
  - Acceptance at edge N → seg outputs and done change at edge N+17.
  - ready returns to 1 after edge N+17; the next acceptance is at edge N+18 or later.
  - Sustained throughput: one value per 18 cycles.
- data_valid while ready=0 is ignored (dropped, not queued). seg outputs hold their previous values until ENCODE.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k (k=4 down to DP_POS+1) is blank if it and all higher magnitude digits are 0.
  - Digits at or below DP_POS are never blanked.
  - With DP_POS=7, digit 0 is never blanked.
- Sign digit:
  - seg5 = BF if sign=1, else FF.
  - Zero is never negative.
  - The sign stays on seg5 regardless of blanking.
- Decimal point: applied only to digit DP_POS. It is never applied to a blanked digit, and by the rule above that digit is never blanked.
- done and ready are never 1 in the same cycle except in the cycle after ENCODE, when done=1 and ready=1.

Test Plan:
- Reset, then hold idle → ready=1, done=0, seg5..seg0 = FF,FF,FF,FF,FF,FF.
- data_in=1234, one-cycle valid → done exactly 17 cycles after acceptance; seg5..seg0 = FF,FF,79,A4,B0,99.
- data_in=-32768 → seg5..seg0 = BF,B0,24,F8,82,80; data_in=-5 → BF,FF,40,C0,C0,92.
- data_in=0 → FF,FF,40,C0,C0,C0. Repeat with BLANK_LZ=0, DP_POS=7 → FF,C0,C0,C0,C0,C0.
- Accept 1234, then pulse valid with 999 while ready=0 → a single done pulse; segs show 1234; 999 is never displayed.
- Accept 1234, assert reset_n=0 at cycle 8 for 2 cycles, then release → all segs FF, no done pulse, ready=1, and the next conversion completes normally.
